// File: rtl/life_scan_sched.sv
// Scan/generation sequencer for the life grid: drives the display scan counter and row
// rotation, and slots pattern loads and generation steps into frame boundaries.
module life_scan_sched #(
   parameter int X              = 8,
   parameter int Y              = 8,
   parameter int LOG2X          = 3,
   parameter int LOG2Y          = 3,
   parameter int FRAMES_PER_GEN = 16,
   parameter int FW             = 5,
   parameter int GW             = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run,
   input  logic                   step,
   input  logic                   load_valid,
   input  logic [X-1:0]           load_data,
   output logic                   load_ready,
   output logic [LOG2X+LOG2Y-1:0] cnt,
   output logic                   shift_en,
   output logic                   load_sel,
   output logic                   gen_en,
   output logic [GW-1:0]          gen_count,
   output logic                   busy
);

   localparam int                CW         = LOG2X + LOG2Y;
   localparam logic [FW-1:0]     FRAME_LAST = FW'(FRAMES_PER_GEN - 1);
   localparam logic [LOG2Y-1:0]  ROW_LAST   = LOG2Y'(Y - 1);

   typedef enum logic [1:0] {
      ST_SCAN = 2'd0,
      ST_LOAD = 2'd1,
      ST_GEN  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [FW-1:0]     frame_cnt_q, frame_cnt_d;
   logic [LOG2Y-1:0]  row_cnt_q, row_cnt_d;
   logic [GW-1:0]     gen_count_q, gen_count_d;
   logic              step_pend_q, step_pend_d;
   logic              frame_end;
   logic              frame_last;
   logic              unused_load_data;

   // Row data goes straight to the grid; only the handshake is sequenced here.
   assign unused_load_data = ^load_data;

   assign frame_end  = (state_q == ST_SCAN) && (&cnt_q);
   assign frame_last = (frame_cnt_q == FRAME_LAST);
   assign cnt        = cnt_q;
   assign gen_count  = gen_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_SCAN;
         cnt_q       <= '0;
         frame_cnt_q <= '0;
         row_cnt_q   <= '0;
         gen_count_q <= '0;
         step_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         frame_cnt_q <= frame_cnt_d;
         row_cnt_q   <= row_cnt_d;
         gen_count_q <= gen_count_d;
         step_pend_q <= step_pend_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      frame_cnt_d = frame_cnt_q;
      row_cnt_d   = row_cnt_q;
      gen_count_d = gen_count_q;
      step_pend_d = step_pend_q | step;
      shift_en    = 1'b0;
      load_sel    = 1'b0;
      gen_en      = 1'b0;
      load_ready  = 1'b0;
      busy        = 1'b0;

      case (state_q)
         ST_SCAN: begin
            cnt_d    = cnt_q + 1'b1;
            shift_en = &cnt_q[LOG2X-1:0];
            if (frame_end) begin
               // Holding at the last frame lets a late run=1 trigger at the next boundary.
               if (!frame_last) begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end
               if (load_valid) begin
                  state_d = ST_LOAD;
               end else if (step_pend_q || (run && frame_last)) begin
                  state_d = ST_GEN;
               end
            end
         end

         ST_LOAD: begin
            cnt_d      = '0;
            load_ready = 1'b1;
            busy       = 1'b1;
            if (load_valid) begin
               shift_en  = 1'b1;
               load_sel  = 1'b1;
               row_cnt_d = row_cnt_q + 1'b1;
               if (row_cnt_q == ROW_LAST) begin
                  row_cnt_d   = '0;
                  gen_count_d = '0;
                  frame_cnt_d = '0;
                  step_pend_d = step;
                  state_d     = ST_SCAN;
               end
            end
         end

         ST_GEN: begin
            cnt_d       = '0;
            gen_en      = 1'b1;
            busy        = 1'b1;
            gen_count_d = gen_count_q + 1'b1;
            frame_cnt_d = '0;
            step_pend_d = step;
            state_d     = ST_SCAN;
         end

         default: begin
            cnt_d   = '0;
            state_d = ST_SCAN;
         end
      endcase

      // A reset cycle must not leak a beat or generation strobe from the aborted state.
      if (reset) begin
         shift_en   = 1'b0;
         load_sel   = 1'b0;
         gen_en     = 1'b0;
         load_ready = 1'b0;
         busy       = 1'b0;
      end
   end

endmodule

// File: tb/tb_life_scan_sched.sv
// Directed bench for life_scan_sched: a per-cycle vector table followed by
// hand-written multi-frame sequences (auto-run, step, load, load-vs-generation).
module tb_life_scan_sched;

   localparam int X = 8;
   localparam int Y = 8;
   localparam int LOG2X = 3;
   localparam int LOG2Y = 3;
   localparam int FPG = 16;
   localparam int FW = 5;
   localparam int GW = 16;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   run;
   logic                   step;
   logic                   load_valid;
   logic [X-1:0]           load_data;
   logic                   load_ready;
   logic [LOG2X+LOG2Y-1:0] cnt;
   logic                   shift_en;
   logic                   load_sel;
   logic                   gen_en;
   logic [GW-1:0]          gen_count;
   logic                   busy;

   int checks = 0;
   int failures = 0;

   life_scan_sched #(
      .X(X), .Y(Y), .LOG2X(LOG2X), .LOG2Y(LOG2Y),
      .FRAMES_PER_GEN(FPG), .FW(FW), .GW(GW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .run(run),
      .step(step),
      .load_valid(load_valid),
      .load_data(load_data),
      .load_ready(load_ready),
      .cnt(cnt),
      .shift_en(shift_en),
      .load_sel(load_sel),
      .gen_en(gen_en),
      .gen_count(gen_count),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int skip;
      int rst, run, stp, lv;
      int cnt, sh, sel, gen, rdy, bsy, gc;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs[NV];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run = 1'b0;
      step = 1'b0;
      load_valid = 1'b0;
      next_cycle();
      reset = 1'b0;
   endtask

   initial begin
      int first_gen, second_gen, gens, first_rdy, beats, shifts, e_cnt, e_gc;
      bit e_rdy, e_gen, e_beat, e_sh;

      reset = 1'b1;
      run = 1'b0;
      step = 1'b0;
      load_valid = 1'b0;
      load_data = 8'hA5;
      next_cycle();

      // skip, rst run stp lv, cnt sh sel gen rdy bsy gc
      vecs[0]  = '{0,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
      vecs[2]  = '{6,  0, 0, 0, 0,  7, 1, 0, 0, 0, 0, 0};
      vecs[3]  = '{0,  0, 0, 0, 0,  8, 0, 0, 0, 0, 0, 0};
      vecs[4]  = '{0,  0, 0, 1, 0,  9, 0, 0, 0, 0, 0, 0};
      vecs[5]  = '{53, 0, 0, 0, 0, 63, 1, 0, 0, 0, 0, 0};
      vecs[6]  = '{0,  0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0};
      vecs[7]  = '{0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1};
      vecs[8]  = '{0,  0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 1};
      vecs[9]  = '{61, 0, 0, 0, 1, 63, 1, 0, 0, 0, 0, 1};
      vecs[10] = '{0,  0, 0, 0, 1,  0, 1, 1, 0, 1, 1, 1};
      vecs[11] = '{0,  0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1};
      vecs[12] = '{2,  0, 0, 0, 1,  0, 1, 1, 0, 1, 1, 1};
      vecs[13] = '{0,  1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1};
      vecs[14] = '{0,  0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0};
      vecs[15] = '{0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0};

      for (int i = 0; i < NV; i++) begin
         reset = (vecs[i].rst != 0);
         run = (vecs[i].run != 0);
         step = (vecs[i].stp != 0);
         load_valid = (vecs[i].lv != 0);
         for (int k = 0; k < vecs[i].skip; k++) next_cycle();
         @(negedge clk);
         chk($sformatf("v%0d_cnt", i), int'(cnt), vecs[i].cnt);
         chk($sformatf("v%0d_shift_en", i), int'(shift_en), vecs[i].sh);
         chk($sformatf("v%0d_load_sel", i), int'(load_sel), vecs[i].sel);
         chk($sformatf("v%0d_gen_en", i), int'(gen_en), vecs[i].gen);
         chk($sformatf("v%0d_load_ready", i), int'(load_ready), vecs[i].rdy);
         chk($sformatf("v%0d_busy", i), int'(busy), vecs[i].bsy);
         chk($sformatf("v%0d_gen_count", i), int'(gen_count), vecs[i].gc);
         $display("vec %0d: rst=%0d lv=%0d cnt=%0d shift=%0d sel=%0d gen=%0d rdy=%0d busy=%0d gc=%0d",
                  i, reset, load_valid, cnt, shift_en, load_sel, gen_en, load_ready, busy, gen_count);
         next_cycle();
      end

      // Idle scan, then run raised after frame_cnt has saturated
      do_reset();
      first_gen = -1;
      shifts = 0;
      for (int c = 0; c < 1350; c++) begin
         run = (c >= 1290);
         @(negedge clk);
         if (c < 200) begin
            chk($sformatf("idle_cnt_c%0d", c), int'(cnt), c % 64);
            chk($sformatf("idle_shift_c%0d", c), int'(shift_en), int'(c % 8 == 7));
         end
         if (c < 64 && shift_en) shifts++;
         if (gen_en && first_gen < 0) first_gen = c;
         next_cycle();
      end
      chk("idle_shifts_per_frame", shifts, 8);
      chk("late_run_first_gen", first_gen, 1344);
      chk("late_run_gen_count", int'(gen_count), 1);
      $display("seq idle/late-run: first gen_en at cycle %0d", first_gen);

      // Free-running generations
      do_reset();
      run = 1'b1;
      first_gen = -1;
      second_gen = -1;
      for (int c = 0; c < 2100; c++) begin
         @(negedge clk);
         if (c == 1025) chk("run_gen_count_1", int'(gen_count), 1);
         if (gen_en) begin
            if (first_gen < 0) first_gen = c;
            else if (second_gen < 0) second_gen = c;
         end
         next_cycle();
      end
      chk("run_first_gen", first_gen, 1024);
      chk("run_second_gen", second_gen, 2049);
      $display("seq run: gen_en at cycles %0d and %0d", first_gen, second_gen);

      // Coalesced steps, and a step in the GEN cycle surviving the clear
      for (int cfg = 0; cfg < 2; cfg++) begin
         do_reset();
         gens = 0;
         first_gen = -1;
         second_gen = -1;
         for (int c = 0; c <= 200; c++) begin
            step = (cfg == 0) ? (c == 10 || c == 30) : (c == 10 || c == 64);
            @(negedge clk);
            if (gen_en) begin
               gens++;
               if (first_gen < 0) first_gen = c;
               else if (second_gen < 0) second_gen = c;
            end
            next_cycle();
         end
         step = 1'b0;
         chk($sformatf("step%0d_gens", cfg), gens, cfg + 1);
         chk($sformatf("step%0d_first_gen", cfg), first_gen, 64);
         chk($sformatf("step%0d_gen_count", cfg), int'(gen_count), cfg + 1);
         if (cfg == 1) chk("step1_second_gen", second_gen, 129);
         $display("seq step cfg %0d: %0d gen_en, first at %0d", cfg, gens, first_gen);
      end

      // Pattern load with a 3-cycle valid gap; step on the final beat
      do_reset();
      beats = 0;
      for (int c = 0; c <= 210; c++) begin
         step = (c == 2 || c == 139);
         load_valid = (c >= 85 && c <= 132) || (c >= 136 && c <= 139);
         if (c <= 63) e_cnt = c;
         else if (c == 64) e_cnt = 0;
         else if (c <= 128) e_cnt = c - 65;
         else if (c <= 139) e_cnt = 0;
         else if (c <= 203) e_cnt = c - 140;
         else if (c == 204) e_cnt = 0;
         else e_cnt = c - 205;
         if (c <= 64) e_gc = 0;
         else if (c <= 139) e_gc = 1;
         else if (c <= 204) e_gc = 0;
         else e_gc = 1;
         e_rdy = (c >= 129 && c <= 139);
         e_gen = (c == 64 || c == 204);
         e_beat = e_rdy && load_valid;
         e_sh = e_rdy ? e_beat : (e_gen ? 1'b0 : (e_cnt % 8 == 7));
         @(negedge clk);
         chk($sformatf("load_cnt_c%0d", c), int'(cnt), e_cnt);
         chk($sformatf("load_shift_c%0d", c), int'(shift_en), int'(e_sh));
         chk($sformatf("load_sel_c%0d", c), int'(load_sel), int'(e_beat));
         chk($sformatf("load_gen_c%0d", c), int'(gen_en), int'(e_gen));
         chk($sformatf("load_ready_c%0d", c), int'(load_ready), int'(e_rdy));
         chk($sformatf("load_busy_c%0d", c), int'(busy), int'(e_rdy || e_gen));
         chk($sformatf("load_gc_c%0d", c), int'(gen_count), e_gc);
         if (load_valid && load_ready) begin
            beats++;
            $display("load beat %0d at cycle %0d", beats, c);
         end
         next_cycle();
      end
      step = 1'b0;
      load_valid = 1'b0;
      chk("load_beats", beats, 8);

      // Load arriving at the frame end where run would generate
      do_reset();
      run = 1'b1;
      first_gen = -1;
      first_rdy = -1;
      beats = 0;
      for (int c = 0; c < 2070; c++) begin
         load_valid = (c >= 1000 && c <= 1031);
         @(negedge clk);
         if (gen_en && first_gen < 0) first_gen = c;
         if (load_ready && first_rdy < 0) first_rdy = c;
         if (load_valid && load_ready) beats++;
         if (c == 1032) begin
            chk("prio_exit_cnt", int'(cnt), 0);
            chk("prio_exit_ready", int'(load_ready), 0);
         end
         next_cycle();
      end
      load_valid = 1'b0;
      chk("prio_first_ready", first_rdy, 1024);
      chk("prio_beats", beats, 8);
      chk("prio_first_gen", first_gen, 2056);
      $display("seq load-priority: LOAD at %0d, first gen_en at %0d", first_rdy, first_gen);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
